nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder_add4_slice.sv | 27 ++
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 tb/tb_nibble_serial_adder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for nibble-serial datapath blocks: FSM state encoding,
// nibble width and index-width helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width: clog2 of the nibble count, never narrower than one bit.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit ripple-carry adder slice; exposes the carry into bit 3
// so the caller can derive signed overflow.
module add4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);
    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c[NIBBLE_W];
    assign c3 = c[NIBBLE_W-1];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice reused NIB times per operation, with the
// inter-nibble carry held in a register and valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus,
    output logic                 busy
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0]    idx_q;
    logic                carry_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q;
    logic                ovf_q;

    logic [NIBBLE_W-1:0] x_nib;
    logic [NIBBLE_W-1:0] y_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                slice_co;
    logic                slice_c3;
    logic                accept;
    logic                last;

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign last   = (idx_q == LAST_IDX);

    always_comb begin
        x_nib = '0;
        y_nib = '0;
        for (int unsigned n = 0; n < NIB; n++) begin
            if (idx_q == IDX_W'(n)) begin
                x_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
                y_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    add4_slice u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (slice_co),
        .c3 (slice_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= bus.cin;
                idx_q   <= '0;
                sum_q   <= '0;
            end else if (state_q == RUN) begin
                for (int unsigned n = 0; n < NIB; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_q[n*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    end
                end
                carry_q <= slice_co;
                // Wrap explicitly so non-power-of-two nibble counts never run past the end.
                idx_q   <= last ? '0 : idx_q + 1'b1;
                if (last) begin
                    cout_q <= slice_co;
                    ovf_q  <= slice_c3 ^ slice_co;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q == RUN);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases plus a
// randomized back-to-back sweep against an arithmetic reference.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
    localparam int NVEC  = 1000;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    // Result packed as {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic ci);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] s;
        logic             v;
        full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        s    = full[WIDTH-1:0];
        v    = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return {v, full[WIDTH], s};
    endfunction

    function automatic logic [31:0] result();
        return 32'({bus.ovf, bus.cout, bus.sum});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in DONE with out_ready low.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic ci);
        int lat;
        lat = 0;
        while (!bus.in_ready && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        bus.cin      = ci;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIB));
        check({tag, "_result"}, result(), 32'(ref_add(x, y, ci)));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0]      held;
        logic [WIDTH+1:0] q[$];
        logic             pre_acc;
        int               acc;
        int               got;
        int               cyc;
        int               last_acc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result(), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("t1234", 16'h1234, 16'h4321, 1'b1);
        release_result("t1234");
        do_op("tffff", 16'hFFFF, 16'h0001, 1'b0);
        release_result("tffff");
        do_op("t7fff", 16'h7FFF, 16'h0001, 1'b0);
        release_result("t7fff");
        do_op("t8000", 16'h8000, 16'h8000, 1'b0);

        // Backpressure in DONE with a competing producer.
        held         = result();
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        repeat (5) begin
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_held", result(), held);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_exit_busy", 32'(busy), 32'd0);
        check("bp_exit_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_exit_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_idle_held", result(), held);
        tick();
        check("bp_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset during the second RUN cycle.
        bus.in_valid = 1'b1;
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", result(), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();
        do_op("t0f0f", 16'h0F0F, 16'hF0F1, 1'b0);
        release_result("t0f0f");

        // Back-to-back random sweep with the consumer always ready.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = WIDTH'($urandom);
        bus.b         = WIDTH'($urandom);
        bus.cin       = 1'($urandom_range(0, 1));
        acc      = 0;
        got      = 0;
        cyc      = 0;
        last_acc = -1;
        while (got < NVEC && cyc < NVEC * (NIB + 2) + 50) begin
            pre_acc = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (pre_acc) begin
                q.push_back(ref_add(bus.a, bus.b, bus.cin));
                acc++;
                if (last_acc >= 0) check("sweep_spacing", 32'(cyc - last_acc), 32'(NIB + 2));
                last_acc = cyc;
                if (acc < NVEC) begin
                    bus.a   = WIDTH'($urandom);
                    bus.b   = WIDTH'($urandom);
                    bus.cin = 1'($urandom_range(0, 1));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("sweep_spurious", 32'd1, 32'd0);
                end else begin
                    check("sweep_result", result(), 32'(q.pop_front()));
                end
                got++;
            end
        end
        check("sweep_count", 32'(got), 32'(NVEC));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
